// File: rtl/glitch_sequencer.sv
// glitch_sequencer: arms on request, waits for a rising trigger edge, then
// emits a programmable train of glitch pulses (delay, width, gap, count) and
// signals completion with a one-cycle done pulse.
// Optional build macro GLITCH_SEQ_TRIG_SYNC_EN: routes trigger through a
// two-flop synchronizer before edge detection (adds 2 cycles of latency).
module glitch_sequencer #(
  parameter int CNT_W = 32,
  parameter int N_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [N_W-1:0]   cfg_count,
  input  logic             arm,
  input  logic             abort,
  input  logic             trigger,
  output logic             glitch,
  output logic             armed,
  output logic             busy,
  output logic             done,
  output logic [N_W-1:0]   pulse_idx
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_DELAY = 3'd2;
  localparam logic [2:0] S_PULSE = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [N_W-1:0]   N_ZERO   = {N_W{1'b0}};
  localparam logic [N_W-1:0]   N_ONE    = {{(N_W-1){1'b0}}, 1'b1};

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] r_delay;
  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] r_gap;
  logic [N_W-1:0]   r_count;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [N_W-1:0]   r_pidx;
  logic [N_W-1:0]   w_pidx_nxt;
  logic             r_trig_prev;
  logic             w_trig;
  logic             w_edge;
  logic [CNT_W-1:0] w_width_m1;
  logic [N_W-1:0]   w_count_m1;
  logic             w_more;

  logic r_glitch;
  logic r_armed;
  logic r_busy;
  logic r_done;
  logic r_cfg_ready;

`ifdef GLITCH_SEQ_TRIG_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-flop synchronizer for the asynchronous target trigger
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= trigger;
      r_sync2 <= r_sync1;
    end
  end

  assign w_trig = r_sync2;
`else
  assign w_trig = trigger;
`endif

  // Rising edge: high now, low on the previous sample (history tracked always)
  assign w_edge = w_trig & ~r_trig_prev;

  // Zero width still yields a one-cycle pulse; zero count still fires once
  assign w_width_m1 = (r_width == CNT_ZERO) ? CNT_ZERO : (r_width - CNT_ONE);
  assign w_count_m1 = (r_count == N_ZERO)   ? N_ZERO   : (r_count - N_ONE);
  assign w_more     = (r_pidx < w_count_m1);

  // Next-state, down-counter and pulse-index computation
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pidx_nxt  = r_pidx;
    if ((r_state != S_IDLE) && abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (arm) begin
            w_state_nxt = S_ARMED;
            w_pidx_nxt  = N_ZERO;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_ARMED: begin
          if (w_edge) begin
            if (r_delay == CNT_ZERO) begin
              w_state_nxt = S_PULSE;
              w_cnt_nxt   = w_width_m1;
            end else begin
              w_state_nxt = S_DELAY;
              w_cnt_nxt   = r_delay - CNT_ONE;
            end
          end else begin
            w_state_nxt = S_ARMED;
          end
        end
        S_DELAY: begin
          if (r_cnt == CNT_ZERO) begin
            w_state_nxt = S_PULSE;
            w_cnt_nxt   = w_width_m1;
          end else begin
            w_cnt_nxt   = r_cnt - CNT_ONE;
          end
        end
        S_PULSE: begin
          if (r_cnt == CNT_ZERO) begin
            if (!w_more) begin
              w_state_nxt = S_DONE;
            end else if (r_gap == CNT_ZERO) begin
              // Back-to-back pulse: glitch stays high without a dip
              w_state_nxt = S_PULSE;
              w_cnt_nxt   = w_width_m1;
              w_pidx_nxt  = r_pidx + N_ONE;
            end else begin
              w_state_nxt = S_GAP;
              w_cnt_nxt   = r_gap - CNT_ONE;
            end
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        S_GAP: begin
          if (r_cnt == CNT_ZERO) begin
            w_state_nxt = S_PULSE;
            w_cnt_nxt   = w_width_m1;
            w_pidx_nxt  = r_pidx + N_ONE;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State, config capture and registered outputs derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= CNT_ZERO;
      r_pidx      <= N_ZERO;
      r_trig_prev <= 1'b0;
      r_delay     <= CNT_ZERO;
      r_width     <= CNT_ZERO;
      r_gap       <= CNT_ZERO;
      r_count     <= N_ZERO;
      r_glitch    <= 1'b0;
      r_armed     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pidx      <= w_pidx_nxt;
      r_trig_prev <= w_trig;
      if ((r_state == S_IDLE) && cfg_valid) begin
        r_delay <= cfg_delay;
        r_width <= cfg_width;
        r_gap   <= cfg_gap;
        r_count <= cfg_count;
      end else begin
        r_delay <= r_delay;
        r_width <= r_width;
        r_gap   <= r_gap;
        r_count <= r_count;
      end
      r_glitch    <= (w_state_nxt == S_PULSE);
      r_armed     <= (w_state_nxt == S_ARMED);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
      r_cfg_ready <= (w_state_nxt == S_IDLE);
    end
  end

  assign glitch    = r_glitch;
  assign armed     = r_armed;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cfg_ready = r_cfg_ready;
  assign pulse_idx = r_pidx;

endmodule

// File: doc/glitch_sequencer.md
GLITCH_SEQUENCER -- requirements
Module: glitch_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of delay/width/gap counters and config fields.
REQ-002 SHALL have parameter N_W, default 8, width of pulse-count field and pulse index.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port cfg_valid  input  1  config write request.
REQ-006 SHALL have port cfg_ready  output  1  config accepted this cycle when high with cfg_valid.
REQ-007 SHALL have ports cfg_delay, cfg_width, cfg_gap  input  CNT_W each  trigger-to-pulse delay, pulse width, inter-pulse gap (cycles).
REQ-008 SHALL have port cfg_count  input  N_W  pulses per shot.
REQ-009 SHALL have ports arm, abort  input  1 each  arm request; abort request.
REQ-010 SHALL have port trigger  input  1  external target event; rising edge starts shot.
REQ-011 SHALL have port glitch  output  1  drives the glitch input of the PWM glitch generator.
REQ-012 SHALL have ports armed, busy, done  output  1 each  ARMED state; any state but IDLE; one-cycle shot-complete pulse.
REQ-013 SHALL have port pulse_idx  output  N_W  index of the current/last pulse, 0-based.

Function
REQ-014 SHALL implement states IDLE, ARMED, DELAY, PULSE, GAP, DONE.
REQ-015 cfg_ready SHALL equal 1 only in IDLE; config fields latched when cfg_valid && cfg_ready; cfg_valid outside IDLE ignored.
REQ-016 IDLE + arm -> ARMED; same-cycle cfg_valid and arm SHALL arm using the newly latched config.
REQ-017 ARMED: trigger edge = trigger sampled 1 with previous sample 0; edge in cycle T -> DELAY; trigger already high at arm time SHALL NOT count as edge.
REQ-018 glitch SHALL rise in cycle T+1+delay (delay 0 -> T+1), stay high max(width,1) cycles.
REQ-019 After each pulse: if pulses done < max(count,1) -> GAP for gap cycles (gap 0 -> next PULSE immediately, glitch stays high contiguous), then PULSE; else -> DONE.
REQ-020 pulse_idx SHALL be 0 at first pulse, increment on each PULSE entry after the first, hold in DONE/IDLE until next arm.
REQ-021 DONE SHALL last exactly one cycle with done=1, then IDLE; glitch=0 in DONE.
REQ-022 abort in any non-IDLE state SHALL force IDLE next cycle, glitch=0 that cycle, done not asserted; abort in IDLE ignored.
REQ-023 arm outside IDLE SHALL be ignored; trigger outside ARMED SHALL be ignored.
REQ-024 glitch SHALL be a registered output, high only in PULSE.
REQ-025 Counters SHALL compare at full CNT_W width; maximum field values SHALL not wrap early.

Reset
REQ-026 rst SHALL have priority over all inputs including abort.
REQ-027 On rst: state IDLE, glitch=0, armed=0, busy=0, done=0, pulse_idx=0, latched config=0, edge-detect history=0.
REQ-028 rst mid-shot SHALL drop glitch to 0 in the cycle after rst sampled, no done pulse.

Configuration
REQ-029 Macro GLITCH_SEQ_TRIG_SYNC_EN defined: trigger SHALL pass a two-flop synchronizer before edge detect, adding 2 cycles to all trigger-to-glitch latencies (REQ-018 becomes T+3+delay, T = cycle trigger first sampled high at the port).
REQ-030 Macro undefined: trigger SHALL feed edge detect directly, latency per REQ-018.

Verification
REQ-031 cfg delay=5 width=3 gap=0 count=1, arm, trigger rise at T -> glitch high T+6..T+8, done at T+9, busy low T+10.
REQ-032 delay=0 width=0 count=0 -> single 1-cycle glitch at T+1, done at T+2.
REQ-033 delay=2 width=2 gap=4 count=3 -> glitch high T+3..4, T+9..10, T+15..16; pulse_idx 0,1,2; one done pulse.
REQ-034 abort during second PULSE of REQ-033 shot -> glitch 0 next cycle, IDLE, no done; cfg_ready 1.
REQ-035 trigger held high during arm, no falling edge -> stays ARMED, glitch never asserted; cfg_valid while ARMED -> config unchanged.
REQ-036 rst during DELAY -> all outputs reset values next cycle; with GLITCH_SEQ_TRIG_SYNC_EN rerun REQ-031 -> glitch T+8..T+10.
